// File: rtl/pong_frame_engine.sv
// rtl/pong_frame_engine.sv - Pong paddle/ball/score state and per-pixel colour on the pixel clock.
// Optional macro SCORE_DISPLAY_EN draws score bars in the top rows.

module pong_frame_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_X_OFF    = 16,
  parameter int BALL_SZ      = 8,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int POINT_FRAMES = 60
) (
  input  logic        CLOCK_25,
  input  logic        i_rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [3:0]  keys_1,
  input  logic [3:0]  keys_2,
  output logic [2:0]  color,
  output logic [3:0]  o_score_1,
  output logic [3:0]  o_score_2,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic signed [11:0] L_PSPD      = 12'(PAD_SPEED);
  localparam logic signed [11:0] L_BSPD      = 12'(BALL_SPEED);
  localparam logic signed [11:0] L_BSPD_N    = 12'(-BALL_SPEED);
  localparam logic signed [11:0] L_PAD_MAX   = 12'(V_RES - PAD_H);
  localparam logic signed [11:0] L_PAD_MID   = 12'((V_RES - PAD_H) / 2);
  localparam logic signed [11:0] L_BALL_CX   = 12'((H_RES - BALL_SZ) / 2);
  localparam logic signed [11:0] L_BALL_CY   = 12'((V_RES - BALL_SZ) / 2);
  localparam logic signed [11:0] L_BALL_XMAX = 12'(H_RES - BALL_SZ);
  localparam logic signed [11:0] L_BALL_YMAX = 12'(V_RES - BALL_SZ);
  localparam logic signed [11:0] L_BSZ       = 12'(BALL_SZ);
  localparam logic signed [11:0] L_PADH      = 12'(PAD_H);
  localparam logic signed [11:0] L_LBACK     = 12'(PAD_X_OFF);
  localparam logic signed [11:0] L_LFACE     = 12'(PAD_X_OFF + PAD_W);
  localparam logic signed [11:0] L_RFACE     = 12'(H_RES - PAD_X_OFF - PAD_W);
  localparam logic signed [11:0] L_RBACK     = 12'(H_RES - PAD_X_OFF);
  localparam logic signed [11:0] L_RHIT_X    = 12'(H_RES - PAD_X_OFF - PAD_W - BALL_SZ);

  localparam logic [11:0] L_HRES_U  = 12'(H_RES);
  localparam logic [11:0] L_VRES_U  = 12'(V_RES);
  localparam logic [11:0] L_BSZ_U   = 12'(BALL_SZ);
  localparam logic [11:0] L_PADH_U  = 12'(PAD_H);
  localparam logic [11:0] L_LBACK_U = 12'(PAD_X_OFF);
  localparam logic [11:0] L_LFACE_U = 12'(PAD_X_OFF + PAD_W);
  localparam logic [11:0] L_RFACE_U = 12'(H_RES - PAD_X_OFF - PAD_W);
  localparam logic [11:0] L_RBACK_U = 12'(H_RES - PAD_X_OFF);
  localparam logic [11:0] L_CL_LO   = 12'(H_RES / 2 - 2);
  localparam logic [11:0] L_CL_HI   = 12'(H_RES / 2 + 1);
  localparam logic [3:0]  L_WIN     = 4'(WIN_SCORE);
  localparam logic [7:0]  L_PF_LAST = 8'(POINT_FRAMES - 1);

  state_t             r_state;
  logic [2:0]         r_k1_s1, r_k1_s2, r_k2_s1, r_k2_s2;
  logic               r_srv1_d, r_srv2_d, r_serve_pend;
  logic [11:0]        r_prev_y;
  logic signed [11:0] r_top1, r_top2, r_bx, r_by, r_dx, r_dy;
  logic [3:0]         r_score1, r_score2;
  logic [7:0]         r_cnt;
  logic [2:0]         r_color;

  logic               w_tick, w_serve_edge, w_serve, w_unused;
  logic signed [11:0] w_nx, w_ny, w_by_n, w_dy_n;
  logic               w_ov_l, w_ov_r, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic [3:0]         w_s1_inc, w_s2_inc;
  logic [11:0]        w_bx_u, w_by_u, w_t1_u, w_t2_u;
  logic               w_in_ball, w_in_lpad, w_in_rpad, w_in_cline;
  logic [2:0]         w_color;

  assign w_unused     = keys_1[3] ^ keys_2[3];
  assign w_tick       = (y == 12'd0) && (r_prev_y != 12'd0);
  assign w_serve_edge = (r_k1_s2[2] & ~r_srv1_d) | (r_k2_s2[2] & ~r_srv2_d);
  assign w_serve      = r_serve_pend | w_serve_edge;
  assign w_s1_inc     = (r_score1 == L_WIN) ? r_score1 : r_score1 + 4'd1;
  assign w_s2_inc     = (r_score2 == L_WIN) ? r_score2 : r_score2 + 4'd1;

  function automatic logic signed [11:0] f_pad(input logic signed [11:0] top,
                                               input logic up, input logic dn);
    logic signed [11:0] t;
    t = top;
    if (up && !dn)      t = top - L_PSPD;
    else if (dn && !up) t = top + L_PSPD;
    if (t[11])               t = '0;
    else if (t > L_PAD_MAX)  t = L_PAD_MAX;
    return t;
  endfunction

  // Ball step: wall bounce and paddle/miss decisions all use pre-tick positions.
  always_comb begin
    w_nx   = r_bx + r_dx;
    w_ny   = r_by + r_dy;
    w_by_n = w_ny;
    w_dy_n = r_dy;
    if (w_ny[11]) begin
      w_by_n = '0;
      w_dy_n = L_BSPD;
    end else if (w_ny > L_BALL_YMAX) begin
      w_by_n = L_BALL_YMAX;
      w_dy_n = L_BSPD_N;
    end
    w_ov_l   = (r_by + L_BSZ > r_top1) && (r_by < r_top1 + L_PADH);
    w_ov_r   = (r_by + L_BSZ > r_top2) && (r_by < r_top2 + L_PADH);
    w_hit_l  = r_dx[11] && (w_nx <= L_LFACE) && (w_nx + L_BSZ > L_LBACK) && w_ov_l;
    w_hit_r  = !r_dx[11] && (w_nx + L_BSZ >= L_RFACE) && (w_nx < L_RBACK) && w_ov_r;
    w_miss_l = w_nx[11] || (w_nx == '0);
    w_miss_r = (w_nx >= L_BALL_XMAX);
  end

  assign w_bx_u     = $unsigned(r_bx);
  assign w_by_u     = $unsigned(r_by);
  assign w_t1_u     = $unsigned(r_top1);
  assign w_t2_u     = $unsigned(r_top2);
  assign w_in_ball  = (x >= w_bx_u) && (x < w_bx_u + L_BSZ_U) &&
                      (y >= w_by_u) && (y < w_by_u + L_BSZ_U);
  assign w_in_lpad  = (x >= L_LBACK_U) && (x < L_LFACE_U) &&
                      (y >= w_t1_u) && (y < w_t1_u + L_PADH_U);
  assign w_in_rpad  = (x >= L_RFACE_U) && (x < L_RBACK_U) &&
                      (y >= w_t2_u) && (y < w_t2_u + L_PADH_U);
  assign w_in_cline = (x >= L_CL_LO) && (x <= L_CL_HI) && !y[4];

`ifdef SCORE_DISPLAY_EN
  localparam logic [11:0] L_S1_END = 12'(H_RES / 2 - 16 + 5);
  localparam logic [11:0] L_S2_BEG = 12'(H_RES / 2 + 10);
  logic [11:0] w_d1, w_d2;
  logic        w_score_px;
  // Bar index is the 8 px pitch slot, measured away from the centre line.
  assign w_d1       = L_S1_END - x;
  assign w_d2       = x - L_S2_BEG;
  assign w_score_px = (y >= 12'd4) && (y <= 12'd11) &&
                      (((x <= L_S1_END) && (w_d1[2:0] < 3'd6) && (w_d1[11:3] < {5'd0, r_score1})) ||
                       ((x >= L_S2_BEG) && (w_d2[2:0] < 3'd6) && (w_d2[11:3] < {5'd0, r_score2})));
`endif

  always_comb begin
    w_color = 3'b000;
    if (x >= L_HRES_U || y >= L_VRES_U) w_color = 3'b000;
    else if (w_in_ball)                 w_color = 3'b111;
`ifdef SCORE_DISPLAY_EN
    else if (w_score_px)                w_color = 3'b110;
`endif
    else if (w_in_lpad)                 w_color = 3'b100;
    else if (w_in_rpad)                 w_color = 3'b001;
    else if (w_in_cline)                w_color = 3'b010;
  end

  always_ff @(posedge CLOCK_25) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_k1_s1      <= '0;
      r_k1_s2      <= '0;
      r_k2_s1      <= '0;
      r_k2_s2      <= '0;
      r_srv1_d     <= 1'b0;
      r_srv2_d     <= 1'b0;
      r_serve_pend <= 1'b0;
      r_prev_y     <= '0;
      r_top1       <= L_PAD_MID;
      r_top2       <= L_PAD_MID;
      r_bx         <= L_BALL_CX;
      r_by         <= L_BALL_CY;
      r_dx         <= L_BSPD;
      r_dy         <= L_BSPD;
      r_score1     <= '0;
      r_score2     <= '0;
      r_cnt        <= '0;
      r_color      <= '0;
    end else begin
      r_k1_s1  <= keys_1[2:0];
      r_k1_s2  <= r_k1_s1;
      r_k2_s1  <= keys_2[2:0];
      r_k2_s2  <= r_k2_s1;
      r_srv1_d <= r_k1_s2[2];
      r_srv2_d <= r_k2_s2[2];
      r_prev_y <= y;
      r_color  <= w_color;
      if (w_tick) begin
        r_serve_pend <= 1'b0;
        if (r_state != S_OVER) begin
          r_top1 <= f_pad(r_top1, r_k1_s2[0], r_k1_s2[1]);
          r_top2 <= f_pad(r_top2, r_k2_s2[0], r_k2_s2[1]);
        end
        case (r_state)
          S_IDLE: if (w_serve) r_state <= S_PLAY;
          S_PLAY: begin
            r_by <= w_by_n;
            r_dy <= w_dy_n;
            if (w_hit_l) begin
              r_bx <= L_LFACE;
              r_dx <= L_BSPD;
            end else if (w_hit_r) begin
              r_bx <= L_RHIT_X;
              r_dx <= L_BSPD_N;
            end else if (w_miss_l) begin
              // Player 1 lost the point, so the next serve heads left.
              r_score2 <= w_s2_inc;
              r_bx     <= L_BALL_CX;
              r_by     <= L_BALL_CY;
              r_dx     <= L_BSPD_N;
              r_cnt    <= '0;
              r_state  <= (w_s2_inc == L_WIN) ? S_OVER : S_POINT;
            end else if (w_miss_r) begin
              r_score1 <= w_s1_inc;
              r_bx     <= L_BALL_CX;
              r_by     <= L_BALL_CY;
              r_dx     <= L_BSPD;
              r_cnt    <= '0;
              r_state  <= (w_s1_inc == L_WIN) ? S_OVER : S_POINT;
            end else begin
              r_bx <= w_nx;
            end
          end
          S_POINT: begin
            if (r_cnt == L_PF_LAST) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_OVER: begin
            if (w_serve) begin
              r_score1 <= '0;
              r_score2 <= '0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_serve_edge) begin
        r_serve_pend <= 1'b1;
      end
    end
  end

  assign color     = r_color;
  assign o_score_1 = r_score1;
  assign o_score_2 = r_score2;
  assign o_state   = r_state;

endmodule

// File: doc/pong_frame_engine.md
Name: pong_frame_engine

Overview:
- Game-logic and pixel-colour stage directly downstream of the VGA timing and x/y counter stage.
- Consumes the pixel coordinates x/y and both players' key vectors, and keeps paddle, ball and score state updated once per frame.
- Produces the 3-bit {red, green, blue} colour for the current pixel.
- Runs entirely on the 25 MHz pixel clock.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in lines
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- PAD_X_OFF, 16, paddle distance from the screen edge
- BALL_SZ, 8, ball edge length (square ball)
- PAD_SPEED, 4, paddle pixels per frame
- BALL_SPEED, 2, ball pixels per frame per axis
- WIN_SCORE, 9, score that ends the game
- POINT_FRAMES, 60, freeze length after a point

Ports:
- CLOCK_25  in  1  pixel clock; everything is on its rising edge
- i_rst  in  1  synchronous reset, active-high
- x  in  12  current pixel column, from the upstream counter
- y  in  12  current pixel line; held at 0 during vertical blank
- keys_1  in  4  player 1 keys: [0] up, [1] down, [2] serve, [3] unused; active-high
- keys_2  in  4  player 2 keys, same encoding as keys_1
- color  out  3  {r,g,b} for the current pixel
- o_score_1  out  4  player 1 score
- o_score_2  out  4  player 2 score
- o_state  out  2  FSM state: 0 IDLE, 1 PLAY, 2 POINT, 3 OVER

Behaviour:
- Reset: takes effect on the next clock edge.
  - color=0, scores=0, o_state=IDLE.
  - Paddles vertically centred: top = (V_RES-PAD_H)/2.
  - Ball at ((H_RES-BALL_SZ)/2, (V_RES-BALL_SZ)/2), dx=+BALL_SPEED, dy=+BALL_SPEED.
  - Synchroniser flops and frame-counter cleared.
  - A reset asserted mid-frame or mid-point discards all state.
- Keys: each pass through a 2-flop synchroniser. Serve is edge-detected (rising edge only).
- Frame tick: a one-cycle pulse on the first cycle where y==0 and the registered previous y!=0. All game state updates only on the tick.
- Paddles, on tick:
  - up → top -= PAD_SPEED; down → top += PAD_SPEED.
  - Both or neither pressed → no move.
  - Result clamped to [0, V_RES-PAD_H].
  - Paddles move in every state except OVER.
- FSM:
  - IDLE: ball centred. A serve edge from either player, latched until the next tick, moves to PLAY on that tick.
  - PLAY: ball updated every tick as described below.
  - POINT: ball centred. Counts POINT_FRAMES ticks, then goes to IDLE.
  - OVER: entered when either score equals WIN_SCORE. A serve edge clears both scores and goes to IDLE.
- Ball, on a PLAY tick:
  - Arithmetic is 12-bit signed on the intermediate next position nx, ny.
  - Vertical: ny<0 → y=0, dy=+BALL_SPEED. ny>V_RES-BALL_SZ → y=V_RES-BALL_SZ, dy=-BALL_SPEED.
  - Left paddle hit: dx<0, nx<=PAD_X_OFF+PAD_W, nx+BALL_SZ>PAD_X_OFF, and the vertical spans overlap (ball_y+BALL_SZ>top && ball_y<top+PAD_H). Result: x=PAD_X_OFF+PAD_W, dx=+BALL_SPEED.
  - Right paddle hit: mirror of the left case at H_RES-PAD_X_OFF-PAD_W. Result: x=H_RES-PAD_X_OFF-PAD_W-BALL_SZ, dx=-BALL_SPEED.
  - Miss: nx<=0 → player 2 scores; nx>=H_RES-BALL_SZ → player 1 scores.
  - On a miss: go to POINT, or to OVER if the new score equals WIN_SCORE.
  - Next serve goes toward the player who lost the point; dy sign is kept.
  - If a paddle hit and a wall bounce happen on the same tick, both apply.
- Scores saturate at WIN_SCORE; they can never wrap.
- Render: color is registered, with 1 cycle latency from x/y. Priority order:
  1. Outside visible area (x>=H_RES or y>=V_RES) → 000.
  2. Ball → 111.
  3. Left paddle → 100.
  4. Right paddle → 001.
  5. Centre line: x in [H_RES/2-2, H_RES/2+1] and y[4]==0 → 010.
  6. Background → 000.
- Rendering uses the position registers as they are; a tick update appears on the next drawn pixel.

Optional Feature:
- Macro SCORE_DISPLAY_EN.
- Defined: in rows y in [4,11], each player's score is drawn as bars 6 px wide on an 8 px pitch.
  - Player 1 bars start at x=H_RES/2-16 and grow leftward.
  - Player 2 bars start at x=H_RES/2+10 and grow rightward.
  - Bar colour is 110. Priority sits between the ball and the paddles.
- Undefined: no score pixels are drawn and the logic is absent. Score ports still function.

Test Plan:
- Reset, then sweep a full frame → color=000 everywhere except the paddles (100 at x 16..23, y 208..271; 001 at x 616..623) and the centre line; o_state=0.
- Hold keys_1[0] for 60 ticks → left paddle top clamps at 0. Then hold keys_1[1] for 200 ticks → top=416.
- Serve pulse on keys_2[2] → o_state=1 on the next tick. Ball x advances 316→318→320 and bounces off the bottom at y=472 with dy negated.
- Left paddle parked away from the ball → player 2 score becomes 1, o_state=2 for 60 ticks, then 0; the next serve travels left.
- Force 9 misses → o_state=3 and inputs are frozen. A serve clears the scores and gives o_state=0.
- Assert i_rst during PLAY mid-line → next cycle: color=0, scores=0, ball centred, o_state=0.
